// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide, one bit per clock.
// Signed arithmetic (op[1]) is available only when MULDIV_SIGNED_EN is defined.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_req,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;
  logic        is_div_reg;
  logic [31:0] m_reg;
  logic [63:0] work_reg;
  logic [31:0] a_mag, b_mag;
  logic        accept;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] step_next;
  logic [31:0] res_hi, res_lo;

  assign accept = start && (state_reg != RUN);
  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign stall  = (rd_req && busy) || (start && busy);

`ifdef MULDIV_SIGNED_EN
  logic neg_q_reg, neg_r_reg, dz_reg;
  assign a_mag = (op[1] && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (op[1] && b[31]) ? (~b + 32'd1) : b;
`else
  logic unused_op_sign;
  assign unused_op_sign = op[1];
  assign a_mag = a;
  assign b_mag = b;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count_reg == 5'd31) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // work_reg holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, work_reg[63:32]} + {1'b0, (work_reg[0] ? m_reg : 32'd0)};
    div_shift = {work_reg[63:32], work_reg[31]};
    div_ge    = (div_shift >= {1'b0, m_reg});
    div_rem   = div_shift[31:0] - m_reg;
    if (is_div_reg) begin
      if (div_ge) step_next = {div_rem, work_reg[30:0], 1'b1};
      else        step_next = {div_shift[31:0], work_reg[30:0], 1'b0};
    end else begin
      step_next = {mul_sum, work_reg[31:1]};
    end
  end

  always_comb begin
    res_hi = step_next[63:32];
    res_lo = step_next[31:0];
`ifdef MULDIV_SIGNED_EN
    if (is_div_reg) begin
      if (neg_r_reg) res_hi = ~step_next[63:32] + 32'd1;
      if (dz_reg)         res_lo = 32'hFFFF_FFFF;
      else if (neg_q_reg) res_lo = ~step_next[31:0] + 32'd1;
    end else if (neg_q_reg) begin
      {res_hi, res_lo} = ~step_next + 64'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= 5'd0;
      is_div_reg <= 1'b0;
      m_reg      <= 32'd0;
      work_reg   <= 64'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
`ifdef MULDIV_SIGNED_EN
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
`endif
    end else if (accept) begin
      count_reg  <= 5'd0;
      is_div_reg <= op[0];
      m_reg      <= op[0] ? b_mag : a_mag;
      work_reg   <= {32'd0, (op[0] ? a_mag : b_mag)};
`ifdef MULDIV_SIGNED_EN
      neg_q_reg  <= op[1] && (a[31] ^ b[31]);
      neg_r_reg  <= op[1] && a[31];
      dz_reg     <= (b == 32'd0);
`endif
    end else if (state_reg == RUN) begin
      work_reg  <= step_next;
      count_reg <= count_reg + 5'd1;
      if (count_reg == 5'd31) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of operations plus stall, ignored-start and reset sequences.
// Signed vectors are included when MULDIV_SIGNED_EN is defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        rd_req;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int pass_count = 0;
  int total_count = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_count++;
    if (act === exp) begin
      pass_count++;
      $display("ok   %s: got %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mode 0: scramble operands mid-run; mode 1: rd_req stall plus a second start while busy.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input int mode);
    int k;
    int nbusy;
    int done_at;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    nbusy = 0;
    while (k <= 40 && !done) begin
      if (busy) nbusy++;
      if (mode == 0 && k == 5) begin
        a = ~x; b = y + 32'd3; op = ~o;
      end
      if (mode == 1 && k == 3) begin
        rd_req = 1'b1;
        #1 check({name, "_stall_rdreq"}, {63'd0, stall}, 64'd1);
        rd_req = 1'b0;
      end
      if (mode == 1 && k == 4) begin
        a = 32'd9; b = 32'd3; op = 2'b00; start = 1'b1;
        #1 check({name, "_stall_start"}, {63'd0, stall}, 64'd1);
      end
      if (mode == 1 && k == 5) start = 1'b0;
      k++;
      @(negedge clk);
    end
    done_at = done ? k : -1;
    check({name, "_done_cycle"}, 64'(done_at), 64'd33);
    check({name, "_busy_cycles"}, 64'(nbusy), 64'd32);
    check({name, "_result"}, {hi, lo}, {ehi, elo});
    @(negedge clk);
    check({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; rd_req = 1'b1;
    #12;
    check("reset_outputs", {29'd0, busy, done, stall, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("idle_stall_rdreq", {63'd0, stall}, 64'd0);
    rd_req = 1'b0;

    vecs.push_back('{"umul_max_x2",  2'b00, 32'hFFFF_FFFF, 32'd2,          32'd1,          32'hFFFF_FFFE});
    vecs.push_back('{"udiv_100_7",   2'b01, 32'd100,       32'd7,          32'd2,          32'd14});
    vecs.push_back('{"udiv_by_zero", 2'b01, 32'd5,         32'd0,          32'd5,          32'hFFFF_FFFF});
    vecs.push_back('{"umul_max_sq",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001});
    vecs.push_back('{"umul_shift",   2'b00, 32'h1234_5678, 32'h10,         32'h1,          32'h2345_6780});
    vecs.push_back('{"udiv_max_1",   2'b01, 32'hFFFF_FFFF, 32'd1,          32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{"udiv_small",   2'b01, 32'd7,         32'd100,        32'd7,          32'd0});
    vecs.push_back('{"udiv_1m_3",    2'b01, 32'd1000000,   32'd3,          32'd1,          32'd333333});
`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{"sdiv_m7_2",    2'b11, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD});
    vecs.push_back('{"smul_m3_5",    2'b10, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1});
    vecs.push_back('{"sdiv_ovf",     2'b11, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          32'h8000_0000});
    vecs.push_back('{"sdiv_m5_0",    2'b11, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF});
    vecs.push_back('{"sdiv_7_m2",    2'b11, 32'd7,         32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD});
`else
    vecs.push_back('{"op1_ignored_mul", 2'b10, 32'hFFFF_FFFD, 32'd5,       32'd4,          32'hFFFF_FFF1});
    vecs.push_back('{"op1_ignored_div", 2'b11, 32'hFFFF_FFF9, 32'd2,       32'd1,          32'h7FFF_FFFC});
`endif

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);

    run_op("ignored_start", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    rd_req = 1'b1;
    #1 check("idle_stall_after", {63'd0, stall}, 64'd0);
    rd_req = 1'b0;

    // Reset pulsed in the tenth RUN cycle must abandon the operation.
    @(negedge clk);
    op = 2'b00; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1 check("midrun_reset_state", {30'd0, busy, done, hi}, 64'd0);
    check("midrun_reset_lo", {32'd0, lo}, 64'd0);
    #1 reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("midrun_no_done", 64'(seen_done), 64'd0);
    check("midrun_no_write", {hi, lo}, 64'd0);
    run_op("after_reset_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port `start`, input, 1 bit: request a multiply or divide of `a` and `b`.
REQ-005 Port `op`, input, 2 bits: bit0 selects the operation (0 = multiply, 1 = divide); bit1 selects signed (1) or unsigned (0).
REQ-006 Port `a`, input, 32 bits: multiplicand or dividend.
REQ-007 Port `b`, input, 32 bits: multiplier or divisor.
REQ-008 Port `rd_req`, input, 1 bit: the pipeline wants to read `hi` or `lo` this cycle.
REQ-009 Port `busy`, output, 1 bit: an operation is in progress.
REQ-010 Port `done`, output, 1 bit: one-cycle pulse when `hi`/`lo` hold a new result.
REQ-011 Port `stall`, output, 1 bit: the pipeline must hold.
REQ-012 Port `hi`, output, 32 bits: HI result register.
REQ-013 Port `lo`, output, 32 bits: LO result register.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, `start`=1 SHALL latch `a`, `b` and `op`, clear the 5-bit step counter, and move to RUN.
REQ-016 `start` SHALL be ignored while in RUN.
REQ-017 RUN SHALL execute exactly 32 iterations, one per clock:
- multiply: shift-add, 64-bit partial product;
- divide: restoring, one quotient bit per cycle.
REQ-018 When the counter reaches 31, RUN SHALL move to DONE on that edge, writing the result:
- multiply: {`hi`,`lo`} = 64-bit product;
- divide: `lo` = quotient, `hi` = remainder.
REQ-019 Latency: with `start` sampled at edge N, `busy` SHALL be 1 from after N through edge N+32; `done` and the new `hi`/`lo` SHALL appear after edge N+32.
REQ-020 DONE SHALL last one cycle and then return to IDLE, unless `start`=1, in which case it goes to RUN.
REQ-021 `busy` SHALL be 1 only in RUN; `done` SHALL be 1 only in DONE.
REQ-022 `stall` SHALL equal (`rd_req` AND `busy`) OR (`start` AND `busy`), combinationally.
REQ-023 `hi`/`lo` SHALL change only at the transition into DONE and SHALL otherwise hold their value.
REQ-024 Divide by zero (`b`=0 at start) SHALL still take 32 cycles and SHALL produce `lo`=32'hFFFF_FFFF and `hi`=`a`.
REQ-025 Changes on `a`, `b` or `op` during RUN SHALL NOT affect the result.

Reset
REQ-026 Asserting `reset` SHALL immediately force:
- state = IDLE and counter = 0;
- `hi`=0, `lo`=0;
- `busy`=0, `done`=0, `stall`=0.
REQ-027 Reset mid-operation SHALL abandon the operation, with no `done` and no result write.
REQ-028 The first `start` after reset is released SHALL be accepted normally.

Configuration
REQ-029 Macro MULDIV_SIGNED_EN defined: `op[1]`=1 SHALL select signed arithmetic, implemented as follows:
- operand magnitudes are latched at start;
- at the DONE write, the product and quotient are negated when the operand signs differ;
- the remainder takes the sign of the dividend.
REQ-030 Signed divide-by-zero SHALL also give `lo`=32'hFFFF_FFFF and `hi`=`a`.
REQ-031 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL give `lo`=32'h8000_0000 and `hi`=0.
REQ-032 Macro MULDIV_SIGNED_EN undefined: `op[1]` SHALL be ignored, all operations SHALL be unsigned, and the sign logic SHALL NOT be synthesized.

Verification
REQ-033 Unsigned multiply: `a`=32'hFFFF_FFFF, `b`=2, `op`=00 -> `hi`=1, `lo`=32'hFFFF_FFFE, `done` exactly 33 cycles after the start edge.
REQ-034 Unsigned divide: `a`=100, `b`=7, `op`=01 -> `lo`=14, `hi`=2; `busy` high for exactly 32 cycles.
REQ-035 Divide by zero: `a`=5, `b`=0, `op`=01 -> `lo`=32'hFFFF_FFFF, `hi`=5.
REQ-036 Stall and ignored start:
- `rd_req`=1 during RUN -> `stall`=1;
- `rd_req`=1 in IDLE -> `stall`=0;
- a second `start` in RUN -> ignored; the first operation's result is unchanged.
REQ-037 Reset mid-operation: `reset` pulsed at cycle 10 of RUN -> `busy`=0, `hi`=`lo`=0, no `done`; the next operation (`a`=3, `b`=4, multiply) -> `lo`=12.
REQ-038 Signed (MULDIV_SIGNED_EN defined):
- `a`=-7, `b`=2, `op`=11 -> `lo`=-3, `hi`=-1;
- `a`=-3, `b`=5, `op`=10 -> {`hi`,`lo`}=-15.
